// File: rtl/knob_menu_ctrl_if.sv
// ----------------------------------------------------------------------------
// knob_menu_ctrl_if
// Connection bundle between the rotary/button front end, the menu controller
// and the consumers of the slot registers.
// ----------------------------------------------------------------------------
interface knob_menu_ctrl_if #(
   parameter int NSLOT  = 4,
   parameter int W      = 8,
   parameter int KNOB_N = 12
);
   localparam int KW = $clog2(KNOB_N);
   localparam int SW = $clog2(NSLOT);

   logic [KW-1:0]      knob_i;
   logic               btn_ni;
   logic [NSLOT*W-1:0] value_o;
   logic [SW-1:0]      sel_o;
   logic               editing_o;
   logic               upd_o;
   logic [SW-1:0]      upd_idx_o;

   modport master (
      output knob_i, btn_ni,
      input  value_o, sel_o, editing_o, upd_o, upd_idx_o
   );

   modport slave (
      input  knob_i, btn_ni,
      output value_o, sel_o, editing_o, upd_o, upd_idx_o
   );
endinterface

// File: rtl/knob_menu_ctrl.sv
// ----------------------------------------------------------------------------
// knob_menu_ctrl
// Rotary/button driven menu of NSLOT configuration registers with BROWSE and
// EDIT modes, saturating value steps, default restore and idle timeout.
// ----------------------------------------------------------------------------
module knob_menu_ctrl #(
   parameter int                 NSLOT    = 4,
   parameter int                 W        = 8,
   parameter int                 MAXV     = 255,
   parameter logic [NSLOT*W-1:0] INIT_VAL = '0,
   parameter int                 KNOB_N   = 12,
   parameter int                 DEBOUNCE = 40000,
   parameter int                 LONG     = 50000000,
   parameter int                 TIMEOUT  = 500000000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   knob_menu_ctrl_if.slave  bus
);

   localparam int KW  = $clog2(KNOB_N);
   localparam int SW  = $clog2(NSLOT);
   localparam int DBW = $clog2(DEBOUNCE + 1);
   localparam int HW  = $clog2(LONG + 1);
   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam int VW  = W + 4;   // headroom so value + magnitude cannot wrap

   localparam logic [NSLOT-1:0][W-1:0] INIT_ARR = INIT_VAL;

   typedef enum logic {BROWSE, EDIT} mode_e;

   // ---------------------------------------------------------------- button
   logic           btn_s1, btn_s2;    // synchronized, 1 = pressed
   logic           btn_acc;           // debounced, 1 = pressed
   logic [DBW-1:0] db_cnt;
   logic [HW-1:0]  hold_cnt;
   logic           long_done;
   logic           db_flip, short_ev, long_ev, btn_ev;

   // NOTE: sequential state is written with <= so every flop samples the
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
      end else begin
         btn_s1 <= ~bus.btn_ni;
         btn_s2 <= btn_s1;
      end
   end

   assign db_flip  = (btn_s2 != btn_acc) && (db_cnt == DBW'(DEBOUNCE - 1));
   assign long_ev  = btn_acc && !long_done && (hold_cnt == HW'(LONG - 1));
   // Release of a press that never reached LONG is the short event.
   assign short_ev = db_flip && btn_acc && !long_done && !long_ev;
   assign btn_ev   = short_ev || long_ev;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         btn_acc <= 1'b0;
         db_cnt  <= '0;
      end else if (btn_s2 != btn_acc) begin
         if (db_flip) begin
            btn_acc <= btn_s2;
            db_cnt  <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end else begin
         db_cnt <= '0;
      end
   end

   // Hold counter freezes once the long event has fired so it cannot wrap.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_cnt  <= '0;
         long_done <= 1'b0;
      end else if (!btn_acc) begin
         hold_cnt  <= '0;
         long_done <= 1'b0;
      end else if (!long_done) begin
         hold_cnt <= hold_cnt + 1'b1;
         if (long_ev) long_done <= 1'b1;
      end
   end

   // ------------------------------------------------- rotary step detection
   logic          primed;
   logic [KW-1:0] knob_q, knob_nxt, knob_prv;
   logic          step_up, step_dn;

   assign knob_nxt = (knob_q == KW'(KNOB_N - 1)) ? '0 : knob_q + 1'b1;
   assign knob_prv = (knob_q == '0) ? KW'(KNOB_N - 1) : knob_q - 1'b1;
   assign step_up  = primed && (bus.knob_i == knob_nxt);
   assign step_dn  = primed && (bus.knob_i == knob_prv);

   // The reference tracks the rotary input every cycle, so any jump larger
   // than one detent simply resyncs without producing a step.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         primed <= 1'b0;
         knob_q <= '0;
      end else begin
         primed <= 1'b1;
         knob_q <= bus.knob_i;
      end
   end

   // ---------------------------------------------------------- mode / slots
   mode_e                  mode_q;
   logic [SW-1:0]          sel_q;
   logic [NSLOT-1:0][W-1:0] val_q;
   logic                   upd_q;
   logic [SW-1:0]          upd_idx_q;
   logic                   editing_q;
   logic [TW-1:0]          idle_q;
   logic [3:0]             mag;
   logic [W-1:0]           cur_val, step_val;
   logic [VW-1:0]          sum;

`ifdef KNOB_ACCEL_EN
   localparam int AW = 21;
   localparam logic [AW-1:0] ACC_WIN = AW'(1 << 20);

   logic [AW-1:0] acc_tmr;
   logic          acc_valid, acc_up, accel_hit, step_applied;

   assign step_applied = (mode_q == EDIT) && (step_up || step_dn) && !btn_ev;
   assign accel_hit    = acc_valid && (acc_tmr < ACC_WIN) && (acc_up == step_up);
   assign mag          = accel_hit ? 4'd8 : 4'd1;

   // acc_tmr counts cycles since the last applied step and parks at the window
   // edge; leaving EDIT forgets the step history.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_tmr   <= '0;
         acc_valid <= 1'b0;
         acc_up    <= 1'b0;
      end else if (mode_q != EDIT) begin
         acc_valid <= 1'b0;
      end else if (step_applied) begin
         acc_valid <= 1'b1;
         acc_up    <= step_up;
         acc_tmr   <= '0;
      end else if (acc_tmr != ACC_WIN) begin
         acc_tmr <= acc_tmr + 1'b1;
      end
   end
`else
   assign mag = 4'd1;
`endif

   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      cur_val  = val_q[sel_q];
      sum      = VW'(cur_val) + VW'(mag);
      step_val = cur_val;
      if (step_up) begin
         step_val = (sum > VW'(MAXV)) ? W'(MAXV) : sum[W-1:0];
      end else if (step_dn) begin
         step_val = (VW'(cur_val) < VW'(mag)) ? '0 : cur_val - W'(mag);
      end
   end

   // Button events win over a same-cycle rotary step (the step is dropped);
   // a rotary step wins over the idle terminal count and restarts the timer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q    <= BROWSE;
         sel_q     <= '0;
         // NOTE: the slots are ordinary flops with a reset default, not a
         // RAM, so resetting the whole array is intentional.
         val_q     <= INIT_ARR;
         upd_q     <= 1'b0;
         upd_idx_q <= '0;
         editing_q <= 1'b0;
         idle_q    <= '0;
      end else begin
         upd_q <= 1'b0;
         case (mode_q)
            BROWSE: begin
               if (short_ev) begin
                  mode_q    <= EDIT;
                  editing_q <= 1'b1;
                  idle_q    <= '0;
               end else if (!long_ev) begin
                  if (step_up) begin
                     sel_q <= (sel_q == SW'(NSLOT - 1)) ? '0 : sel_q + 1'b1;
                  end else if (step_dn) begin
                     sel_q <= (sel_q == '0) ? SW'(NSLOT - 1) : sel_q - 1'b1;
                  end
               end
            end
            EDIT: begin
               if (short_ev) begin
                  mode_q    <= BROWSE;
                  editing_q <= 1'b0;
                  idle_q    <= '0;
               end else if (long_ev) begin
                  idle_q <= '0;
                  if (cur_val != INIT_ARR[sel_q]) begin
                     val_q[sel_q] <= INIT_ARR[sel_q];
                     upd_q        <= 1'b1;
                     upd_idx_q    <= sel_q;
                  end
               end else if (step_up || step_dn) begin
                  idle_q <= '0;
                  if (step_val != cur_val) begin
                     val_q[sel_q] <= step_val;
                     upd_q        <= 1'b1;
                     upd_idx_q    <= sel_q;
                  end
               end else if (idle_q == TW'(TIMEOUT - 1)) begin
                  mode_q    <= BROWSE;
                  editing_q <= 1'b0;
                  idle_q    <= '0;
               end else begin
                  idle_q <= idle_q + 1'b1;
               end
            end
            default: mode_q <= BROWSE;
         endcase
      end
   end

   assign bus.value_o   = val_q;
   assign bus.sel_o     = sel_q;
   assign bus.editing_o = editing_q;
   assign bus.upd_o     = upd_q;
   assign bus.upd_idx_o = upd_idx_q;

endmodule
